// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM RAM-port arbiter and its
// outstanding-transaction tracker.
package sdram_arb_pkg;

  localparam int PRIORITY_RR    = 0;
  localparam int PRIORITY_FIXED = 1;

  typedef struct packed {
    logic [2:0] port;
    logic [7:0] remaining;
  } track_entry_t;

endpackage

// File: rtl/sdram_arb_track_fifo.sv
// Synchronous FIFO of outstanding downstream transactions; the head entry
// tells the arbiter which port owns the next ack from the core.
module sdram_arb_track_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  track_entry_t push_entry_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output track_entry_t head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  track_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Full/empty come straight from the registered count, so a pop in the
  // same cycle never frees a slot for a push.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

endmodule

// File: rtl/sdram_ram_arbiter.sv
// N-port arbiter in front of the SDRAM core RAM interface: round-robin or
// fixed priority, write-burst locking, in-order ack routing back to ports.
module sdram_ram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int OUTSTANDING   = 4,
  parameter int ADDR_W        = 32,
  parameter int PRIORITY_MODE = PRIORITY_RR
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr_i,
  input  logic [NUM_PORTS*4-1:0]    port_wr_i,
  input  logic [NUM_PORTS-1:0]      port_rd_i,
  input  logic [NUM_PORTS*8-1:0]    port_len_i,
  input  logic [NUM_PORTS*32-1:0]   port_write_data_i,
  output logic [NUM_PORTS-1:0]      port_accept_o,
  output logic [NUM_PORTS-1:0]      port_ack_o,
  output logic [NUM_PORTS-1:0]      port_error_o,
  output logic [31:0]               port_read_data_o,
  output logic [ADDR_W-1:0]         ram_addr_o,
  output logic [3:0]                ram_wr_o,
  output logic                      ram_rd_o,
  output logic [7:0]                ram_len_o,
  output logic [31:0]               ram_write_data_o,
  input  logic                      ram_accept_i,
  input  logic                      ram_ack_i,
  input  logic                      ram_error_i,
  input  logic [31:0]               ram_read_data_i,
  output logic                      unexpected_ack_o
);

  localparam int MAX_PORTS = 8;

  logic [ADDR_W-1:0]    addr_arr  [MAX_PORTS];
  logic [3:0]           wr_arr    [MAX_PORTS];
  logic [7:0]           len_arr   [MAX_PORTS];
  logic [31:0]          wdata_arr [MAX_PORTS];
  logic [MAX_PORTS-1:0] rd_vec;
  logic [MAX_PORTS-1:0] req_vec;

  // Unused port slots read as idle so a 3-bit port index is always legal.
  for (genvar i = 0; i < MAX_PORTS; i++) begin : g_unpack
    if (i < NUM_PORTS) begin : g_used
      assign addr_arr[i]  = port_addr_i[i*ADDR_W +: ADDR_W];
      assign wr_arr[i]    = port_wr_i[i*4 +: 4];
      assign len_arr[i]   = port_len_i[i*8 +: 8];
      assign wdata_arr[i] = port_write_data_i[i*32 +: 32];
      assign rd_vec[i]    = port_rd_i[i];
      assign req_vec[i]   = port_rd_i[i] | (|port_wr_i[i*4 +: 4]);
    end else begin : g_unused
      assign addr_arr[i]  = '0;
      assign wr_arr[i]    = '0;
      assign len_arr[i]   = '0;
      assign wdata_arr[i] = '0;
      assign rd_vec[i]    = 1'b0;
      assign req_vec[i]   = 1'b0;
    end
  end

  logic [2:0]   rr_ptr_q;
  logic         locked_q;
  logic [2:0]   lock_port_q;
  logic [7:0]   beat_cnt_q;
  logic [2:0]   last_grant_q;
  logic [7:0]   ack_cnt_q;

  logic [2:0]   grant;
  logic         grant_valid;
  logic [2:0]   sel;
  logic         is_write;
  logic         issue;
  logic         accepted;
  logic [2:0]   next_ptr;
  logic         ack_hit;
  logic         trk_pop;
  logic         trk_full;
  logic         trk_empty;
  track_entry_t trk_head;
  track_entry_t trk_push_entry;

  // Descending scan: the last hit is the first requester in priority order.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = lock_port_q;
    grant_valid = 1'b0;
    if (locked_q) begin
      grant_valid = req_vec[lock_port_q];
    end else if (PRIORITY_MODE == PRIORITY_FIXED) begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        if (req_vec[k]) begin
          grant       = 3'(k);
          grant_valid = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (req_vec[idx[2:0]]) begin
          grant       = idx[2:0];
          grant_valid = 1'b1;
        end
      end
    end
  end

  assign sel      = grant_valid ? grant : last_grant_q;
  assign is_write = |wr_arr[grant];
  assign issue    = grant_valid & ~trk_full;
  assign accepted = issue & ram_accept_i;
  assign next_ptr = (grant == 3'(NUM_PORTS - 1)) ? 3'd0 : grant + 3'd1;

  assign ram_addr_o       = addr_arr[sel];
  assign ram_len_o        = len_arr[sel];
  assign ram_write_data_o = wdata_arr[sel];
  assign ram_rd_o         = issue & rd_vec[grant] & ~is_write;
  assign ram_wr_o         = issue ? wr_arr[grant] : 4'h0;

  // Reads expect len+1 acks, each write beat exactly one.
  always_comb begin
    trk_push_entry.port      = grant;
    trk_push_entry.remaining = is_write ? 8'd0 : len_arr[grant];
  end

  assign ack_hit          = ram_ack_i & ~trk_empty;
  assign trk_pop          = ack_hit & (ack_cnt_q == trk_head.remaining);
  assign unexpected_ack_o = ram_ack_i & trk_empty;
  assign port_read_data_o = ram_read_data_i;

  always_comb begin
    port_accept_o = '0;
    port_ack_o    = '0;
    port_error_o  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_accept_o[i] = accepted & (grant == 3'(i));
      port_ack_o[i]    = ack_hit & (trk_head.port == 3'(i));
      port_error_o[i]  = ack_hit & ram_error_i & (trk_head.port == 3'(i));
    end
  end

  sdram_arb_track_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_track (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (accepted),
    .push_entry_i (trk_push_entry),
    .pop_i        (trk_pop),
    .full_o       (trk_full),
    .empty_o      (trk_empty),
    .head_o       (trk_head)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      locked_q     <= 1'b0;
      lock_port_q  <= '0;
      beat_cnt_q   <= '0;
      last_grant_q <= '0;
      ack_cnt_q    <= '0;
    end else begin
      if (grant_valid) last_grant_q <= grant;
      if (trk_pop)      ack_cnt_q <= '0;
      else if (ack_hit) ack_cnt_q <= ack_cnt_q + 8'd1;
      // The pointer only moves once a transaction is complete from the
      // port's view: a read, or the final beat of a write burst.
      if (accepted) begin
        if (is_write && locked_q) begin
          beat_cnt_q <= beat_cnt_q - 8'd1;
          if (beat_cnt_q == 8'd1) begin
            locked_q <= 1'b0;
            rr_ptr_q <= next_ptr;
          end
        end else if (is_write && len_arr[grant] != 8'd0) begin
          locked_q    <= 1'b1;
          lock_port_q <= grant;
          beat_cnt_q  <= len_arr[grant];
        end else begin
          rr_ptr_q <= next_ptr;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_ram_arbiter.sv
// Directed and randomized checks of sdram_ram_arbiter against a queue-based
// transaction-level reference model.
module tb_sdram_ram_arbiter;

  localparam int N    = 2;
  localparam int OUTS = 4;
  localparam int AW   = 32;

  localparam bit         T3_P0   [7] = '{1, 0, 1, 1, 1, 0, 0};
  localparam bit         T3_P1   [7] = '{1, 1, 1, 1, 1, 1, 0};
  localparam bit         T3_ACK  [7] = '{0, 1, 0, 1, 1, 1, 1};
  localparam logic [1:0] T3_ACC  [7] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
  localparam logic [1:0] T3_PACK [7] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10};

  logic clk = 1'b0;
  logic rst_n;
  logic [N*AW-1:0] port_addr;
  logic [N*4-1:0]  port_wr;
  logic [N-1:0]    port_rd;
  logic [N*8-1:0]  port_len;
  logic [N*32-1:0] port_wdata;
  logic [N-1:0]    acc, pack, perr;
  logic [31:0]     prdata;
  logic [AW-1:0]   ram_addr;
  logic [3:0]      ram_wr;
  logic            ram_rd;
  logic [7:0]      ram_len;
  logic [31:0]     ram_wdata;
  logic            ram_accept, ram_ack, ram_error;
  logic [31:0]     ram_rdata;
  logic            unexp;

  logic [N-1:0]    f_acc, f_pack, f_perr;
  logic [31:0]     f_prdata;
  logic [AW-1:0]   f_ram_addr;
  logic [3:0]      f_ram_wr;
  logic            f_ram_rd;
  logic [7:0]      f_ram_len;
  logic [31:0]     f_ram_wdata;
  logic            f_unexp;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sdram_ram_arbiter #(.NUM_PORTS(N), .OUTSTANDING(OUTS), .ADDR_W(AW), .PRIORITY_MODE(0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .port_addr_i(port_addr), .port_wr_i(port_wr), .port_rd_i(port_rd),
    .port_len_i(port_len), .port_write_data_i(port_wdata),
    .port_accept_o(acc), .port_ack_o(pack), .port_error_o(perr), .port_read_data_o(prdata),
    .ram_addr_o(ram_addr), .ram_wr_o(ram_wr), .ram_rd_o(ram_rd), .ram_len_o(ram_len),
    .ram_write_data_o(ram_wdata), .ram_accept_i(ram_accept), .ram_ack_i(ram_ack),
    .ram_error_i(ram_error), .ram_read_data_i(ram_rdata), .unexpected_ack_o(unexp)
  );

  sdram_ram_arbiter #(.NUM_PORTS(N), .OUTSTANDING(OUTS), .ADDR_W(AW), .PRIORITY_MODE(1)) dut_fixed (
    .clk_i(clk), .rst_ni(rst_n),
    .port_addr_i(port_addr), .port_wr_i(port_wr), .port_rd_i(port_rd),
    .port_len_i(port_len), .port_write_data_i(port_wdata),
    .port_accept_o(f_acc), .port_ack_o(f_pack), .port_error_o(f_perr), .port_read_data_o(f_prdata),
    .ram_addr_o(f_ram_addr), .ram_wr_o(f_ram_wr), .ram_rd_o(f_ram_rd), .ram_len_o(f_ram_len),
    .ram_write_data_o(f_ram_wdata), .ram_accept_i(ram_accept), .ram_ack_i(ram_ack),
    .ram_error_i(ram_error), .ram_read_data_i(ram_rdata), .unexpected_ack_o(f_unexp)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic set_port(input int p, input bit rd, input logic [3:0] wr, input logic [31:0] addr,
                          input logic [7:0] len, input logic [31:0] data);
    port_rd[p]          = rd;
    port_wr[p*4 +: 4]   = wr;
    port_addr[p*AW +: AW] = addr;
    port_len[p*8 +: 8]  = len;
    port_wdata[p*32 +: 32] = data;
  endtask

  task automatic idle_all();
    for (int p = 0; p < N; p++) set_port(p, 1'b0, 4'h0, 32'h0, 8'h0, 32'h0);
    ram_accept = 1'b0;
    ram_ack    = 1'b0;
    ram_error  = 1'b0;
    ram_rdata  = 32'h0;
  endtask

  // Called at posedge+1; asserts reset for one full cycle.
  task automatic reset_dut();
    idle_all();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  int          q_port[$];
  int          q_left[$];
  int          m_rr, m_last;
  bit          g_busy[N], g_wr[N], pres[N];
  int          g_len[N], g_left[N], g_hold[N];
  logic [31:0] g_addr[N], g_data[N];
  logic [3:0]  g_strb[N];

  initial begin
    int gi, lk, sel;
    bit gv, full, issue, acc_now;
    logic [N-1:0] e_acc, e_pack, e_perr;

    // Reset state and first single read
    idle_all();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_accept", acc, 0);
    chk("rst_ack", pack, 0);
    chk("rst_ram_rd", ram_rd, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_unexp", unexp, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_port(1, 1'b1, 4'h0, 32'h100, 8'd0, 32'h0);
    ram_accept = 1'b1;
    @(negedge clk);
    chk("t1_accept", acc, 2'b10);
    chk("t1_ram_rd", ram_rd, 1);
    chk("t1_ram_addr", ram_addr, 32'h100);
    next_cycle();
    set_port(1, 1'b0, 4'h0, 32'h100, 8'd0, 32'h0);
    ram_accept = 1'b0;
    ram_ack    = 1'b1;
    ram_rdata  = 32'hCAFE0001;
    @(negedge clk);
    chk("t1_ack", pack, 2'b10);
    chk("t1_rdata", prdata, 32'hCAFE0001);
    chk("t1_unexp", unexp, 0);
    next_cycle();
    ram_ack = 1'b0;
    @(negedge clk);
    chk("t1_ack_done", pack, 0);
    next_cycle();

    // Continuous reads on both ports: RR alternates, fixed keeps port 0
    reset_dut();
    set_port(0, 1'b1, 4'h0, 32'h10, 8'd0, 32'h0);
    set_port(1, 1'b1, 4'h0, 32'h20, 8'd0, 32'h0);
    ram_accept = 1'b1;
    ram_ack    = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("t2_rr_accept_%0d", c), acc, (c % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("t2_fixed_accept_%0d", c), f_acc, 2'b01);
      chk($sformatf("t2_fixed_addr_%0d", c), f_ram_addr, 32'h10);
      next_cycle();
    end

    // Port 0 write burst len 3 (with an idle gap) locks out a pending port 1 read
    reset_dut();
    ram_accept = 1'b1;
    for (int c = 0; c < 7; c++) begin
      set_port(0, 1'b0, T3_P0[c] ? 4'hF : 4'h0, 32'h300 + c, 8'd3, 32'hD0 + c);
      set_port(1, T3_P1[c], 4'h0, 32'h200, 8'd0, 32'h0);
      ram_ack = T3_ACK[c];
      @(negedge clk);
      chk($sformatf("t3_accept_%0d", c), acc, T3_ACC[c]);
      chk($sformatf("t3_ack_%0d", c), pack, T3_PACK[c]);
      next_cycle();
    end

    // Read len 3 on port 0 then len 0 on port 1: acks routed in order
    reset_dut();
    set_port(0, 1'b1, 4'h0, 32'h400, 8'd3, 32'h0);
    set_port(1, 1'b1, 4'h0, 32'h500, 8'd0, 32'h0);
    ram_accept = 1'b1;
    @(negedge clk);
    chk("t4_accept0", acc, 2'b01);
    next_cycle();
    set_port(0, 1'b0, 4'h0, 32'h400, 8'd3, 32'h0);
    @(negedge clk);
    chk("t4_accept1", acc, 2'b10);
    next_cycle();
    set_port(1, 1'b0, 4'h0, 32'h500, 8'd0, 32'h0);
    ram_accept = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ram_ack   = 1'b1;
      ram_error = (k == 3);
      ram_rdata = 32'hA0000000 + k;
      @(negedge clk);
      chk($sformatf("t4_ack_%0d", k), pack, (k < 4) ? 2'b01 : ((k == 4) ? 2'b10 : 2'b00));
      chk($sformatf("t4_err_%0d", k), perr, (k == 3) ? 2'b01 : 2'b00);
      chk($sformatf("t4_rdata_%0d", k), prdata, 32'hA0000000 + k);
      chk($sformatf("t4_unexp_%0d", k), unexp, (k == 5) ? 1 : 0);
      next_cycle();
    end
    ram_ack   = 1'b0;
    ram_error = 1'b0;
    @(negedge clk);
    chk("t4_unexp_pulse_end", unexp, 0);
    next_cycle();

    // Tracker full blocks requests, including the cycle of a pop
    reset_dut();
    set_port(0, 1'b1, 4'h0, 32'h600, 8'd0, 32'h0);
    ram_accept = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("t5_accept_%0d", c), acc, 2'b01);
      next_cycle();
    end
    @(negedge clk);
    chk("t5_full_rd", ram_rd, 0);
    chk("t5_full_accept", acc, 0);
    next_cycle();
    ram_ack = 1'b1;
    @(negedge clk);
    chk("t5_full_pop_rd", ram_rd, 0);
    chk("t5_full_pop_ack", pack, 2'b01);
    next_cycle();
    ram_ack = 1'b0;
    @(negedge clk);
    chk("t5_after_pop_rd", ram_rd, 1);
    chk("t5_after_pop_accept", acc, 2'b01);
    next_cycle();

    // Reset in the middle of a locked port 1 burst
    reset_dut();
    set_port(1, 1'b0, 4'h3, 32'h700, 8'd3, 32'h55);
    ram_accept = 1'b1;
    @(negedge clk);
    chk("t7_beat0", acc, 2'b10);
    next_cycle();
    @(negedge clk);
    chk("t7_beat1", acc, 2'b10);
    next_cycle();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    set_port(0, 1'b1, 4'h0, 32'h800, 8'd0, 32'h0);
    set_port(1, 1'b1, 4'h0, 32'h900, 8'd0, 32'h0);
    ram_ack = 1'b1;
    @(negedge clk);
    chk("t7_grant_after_rst", acc, 2'b01);
    chk("t7_unexp_after_rst", unexp, 1);
    chk("t7_no_port_ack", pack, 2'b00);
    next_cycle();

    // Randomized traffic against the transaction-level model
    reset_dut();
    q_port.delete();
    q_left.delete();
    m_rr   = 0;
    m_last = 0;
    for (int p = 0; p < N; p++) begin
      g_busy[p] = 1'b0;
      g_hold[p] = 0;
      g_addr[p] = 32'h0;
      g_data[p] = 32'h0;
      g_len[p]  = 0;
      g_wr[p]   = 1'b0;
      g_strb[p] = 4'h0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int p = 0; p < N; p++) begin
        if (!g_busy[p] && $urandom_range(0, 9) < 4) begin
          g_busy[p] = 1'b1;
          g_wr[p]   = 1'($urandom_range(0, 1));
          g_len[p]  = $urandom_range(0, 3);
          g_left[p] = g_len[p] + 1;
          g_hold[p] = 0;
          g_addr[p] = $urandom;
          g_data[p] = $urandom;
          g_strb[p] = 4'($urandom_range(1, 15));
        end
        pres[p] = g_busy[p] && (g_hold[p] == 0);
        set_port(p, pres[p] && !g_wr[p], (pres[p] && g_wr[p]) ? g_strb[p] : 4'h0,
                 g_addr[p], 8'(g_len[p]), g_data[p]);
      end
      ram_accept = ($urandom_range(0, 3) != 0);
      ram_ack    = ($urandom_range(0, 9) < 4);
      ram_error  = ($urandom_range(0, 7) == 0);
      ram_rdata  = $urandom;

      // A port that has started but not finished a write burst owns the bus.
      lk = -1;
      for (int p = 0; p < N; p++)
        if (g_busy[p] && g_wr[p] && g_left[p] <= g_len[p]) lk = p;
      gv = 1'b0;
      gi = 0;
      if (lk >= 0) begin
        gi = lk;
        gv = pres[lk];
      end else begin
        for (int k = 0; k < N; k++) begin
          if (!gv && pres[(m_rr + k) % N]) begin
            gi = (m_rr + k) % N;
            gv = 1'b1;
          end
        end
      end
      full    = (q_port.size() == OUTS);
      issue   = gv && !full;
      acc_now = issue && ram_accept;
      e_acc   = '0;
      e_pack  = '0;
      e_perr  = '0;
      if (acc_now) e_acc[gi] = 1'b1;
      if (ram_ack && q_port.size() > 0) begin
        e_pack[q_port[0]] = 1'b1;
        e_perr[q_port[0]] = ram_error;
      end
      sel = gv ? gi : m_last;

      @(negedge clk);
      chk("r_accept", acc, e_acc);
      chk("r_ram_rd", ram_rd, issue && !g_wr[gi]);
      chk("r_ram_wr", ram_wr, (issue && g_wr[gi]) ? g_strb[gi] : 4'h0);
      chk("r_ack", pack, e_pack);
      chk("r_err", perr, e_perr);
      chk("r_unexp", unexp, ram_ack && (q_port.size() == 0));
      chk("r_addr", ram_addr, port_addr[sel*AW +: AW]);
      chk("r_len", ram_len, port_len[sel*8 +: 8]);
      chk("r_rdata", prdata, ram_rdata);
      next_cycle();

      if (ram_ack && q_port.size() > 0) begin
        q_left[0] = q_left[0] - 1;
        if (q_left[0] == 0) begin
          void'(q_port.pop_front());
          void'(q_left.pop_front());
        end
      end
      for (int p = 0; p < N; p++) if (g_hold[p] > 0) g_hold[p]--;
      if (gv) m_last = gi;
      if (acc_now) begin
        q_port.push_back(gi);
        q_left.push_back(g_wr[gi] ? 1 : g_len[gi] + 1);
        if (g_wr[gi]) begin
          g_left[gi]--;
          if (g_left[gi] == 0) begin
            g_busy[gi] = 1'b0;
            m_rr = (gi + 1) % N;
          end else begin
            g_hold[gi] = $urandom_range(0, 2);
            g_data[gi] = $urandom;
          end
        end else begin
          g_busy[gi] = 1'b0;
          m_rr = (gi + 1) % N;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sdram_ram_arbiter.md
# sdram_ram_arbiter

Parametrised N-port arbiter that multiplexes several RAM-style request ports onto the single RAM request interface of the SDRAM controller core. It sits between multiple AXI-to-RAM bridges (or other internal masters) and the SDRAM core, so several bus masters can share one SDRAM device. It adds:

- round-robin or fixed-priority arbitration;
- write-burst grant locking;
- an in-order outstanding-transaction tracker that routes acks, errors and read data back to the issuing port.

## Interface
Parameters:
- NUM_PORTS, 2, number of upstream ports (1..8)
- OUTSTANDING, 4, tracker FIFO depth (power of 2, ≥2)
- ADDR_W, 32, address width
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed (port 0 highest)

Ports:
- Clock and reset. One clock; reset is asynchronous and active-low.
  - clk_i  in  1  clock
  - rst_ni  in  1  asynchronous active-low reset
- Upstream ports (packed per port):
  - port_addr_i  in  NUM_PORTS*ADDR_W  request address
  - port_wr_i  in  NUM_PORTS*4  write byte strobes (non-zero = write)
  - port_rd_i  in  NUM_PORTS  read request
  - port_len_i  in  NUM_PORTS*8  burst length − 1
  - port_write_data_i  in  NUM_PORTS*32  write data
  - port_accept_o  out  NUM_PORTS  request accepted this cycle
  - port_ack_o  out  NUM_PORTS  ack beat for this port
  - port_error_o  out  NUM_PORTS  error qualifier with ack
  - port_read_data_o  out  32  read data, broadcast, qualified by port_ack_o
- Downstream interface (to the SDRAM core):
  - ram_addr_o, ram_wr_o, ram_rd_o, ram_len_o, ram_write_data_o  out  ADDR_W/4/1/8/32  request to the core
  - ram_accept_i, ram_ack_i, ram_error_i  in  1 each  core handshake
  - ram_read_data_i  in  32  core read data
- Status:
  - unexpected_ack_o  out  1  one-cycle pulse when an ack arrives with the tracker empty

## Operation
Request contract:
- A port requests by holding rd or non-zero wr, with addr, len and data stable, until port_accept_o is high.
- Read: one accepted request yields len+1 acks.
- Write burst of len+1 beats: len+1 separately accepted write requests, each yielding 1 ack. port_len_i carries the burst length on every beat.

Arbitration:
- Unlocked: the winner is chosen combinationally among requesting ports.
  - RR: first requester at or after rr_ptr.
  - Fixed: lowest index.
- Granted request drives ram_* outputs. port_accept_o[g] = ram_accept_i & grant_valid. Other ports' accept = 0.
- No requester: ram_rd_o = 0 and ram_wr_o = 0; other ram_* outputs hold the last granted port's values.

Lock and round-robin pointer:
- On the first accepted write beat with len>0: lock to that port, beat_cnt = len.
- Each further accepted beat decrements beat_cnt; unlock when it reaches 0.
- While locked, other ports are never granted, even if the locked port idles.
- rr_ptr advances to g+1 (mod NUM_PORTS) on a read accept or the final write beat accept. It is unused in fixed mode.

Tracker (FIFO, entry = {port index, remaining acks}):
- Push on every downstream accept: remaining = len for reads, 0 for writes.
- On ram_ack_i, route ack, error and data to head.port, then decrement head.remaining; pop when it is 0.
- Push and pop in the same cycle are legal.
- Full: ram_rd_o and ram_wr_o are forced to 0, so no accept. Lock and beat_cnt are held.
- Empty with ram_ack_i: ack dropped, unexpected_ack_o pulses.

## Timing
- Request path and ack routing are combinational: zero-cycle latency added.
- Grant lock, rr_ptr, beat_cnt and the tracker update on the clk_i rising edge.
- Reset state:
  - all outputs 0;
  - rr_ptr = 0;
  - unlocked, beat_cnt = 0;
  - tracker empty.
- Reset asserted mid-burst aborts all state immediately. Acks arriving after release while the tracker is empty pulse unexpected_ack_o.
- Tracker full with a simultaneous pop: the request is still blocked that cycle. The full flag is registered.

## Structure
- Package sdram_arb_pkg holds:
  - the tracker entry typedef {logic [2:0] port; logic [7:0] remaining};
  - PRIORITY_RR and PRIORITY_FIXED constants.
- One sub-module: sdram_arb_track_fifo, a synchronous FIFO with OUTSTANDING entries.
  - Interfaces: push/pop/full/empty and head entry out.
  - Also instantiable elsewhere.

## Test plan
- Reset: all port_accept_o and port_ack_o are 0, ram_rd_o = 0. After release, port 1 read at 0x100, len 0 → accepted the first cycle ram_accept_i = 1; one ack on port_ack_o[1].
- RR, 2 ports reading continuously with ram_accept_i = 1 → grants alternate 0,1,0,1. Fixed mode, same stimulus → port 0 always granted.
- Port 0 write burst, len 3, port 1 read pending → port 1 accepted only after the fourth port 0 beat; 4 acks to port 0, then port 1's ack.
- Port 0 read len 3, then port 1 read len 0, core acks 5 times → first 4 acks and data to port 0, fifth to port 1.
- OUTSTANDING = 4, 4 reads accepted, no acks → fifth request has ram_rd_o = 0 until one entry pops.
- ram_ack_i with the tracker empty → unexpected_ack_o pulses 1 cycle, no port ack. Reset asserted mid-burst → lock cleared, next grant from port 0.
